// File: rtl/jelly_address_align_split_multi.sv
// Splits one burst command into chunks that never cross a 2^ALIGN byte boundary,
// with an optional per-chunk beat cap and an end-of-command flag on the last chunk.
module jelly_address_align_split_multi #(
    parameter  int USER_WIDTH  = 0,
    parameter  int ADDR_WIDTH  = 32,
    parameter  int UNIT_SIZE   = 3,
    parameter  int LEN_WIDTH   = 8,
    parameter  int LEN_OFFSET  = 1,
    parameter  int ALIGN       = 12,
    parameter  int MAX_LEN_LOG = 0,
    localparam int USER_BITS   = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cke,

    input  logic                  s_first,
    input  logic                  s_last,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic [USER_BITS-1:0]  s_user,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic                  m_first,
    output logic                  m_last,
    output logic                  m_cmd_last,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic [USER_BITS-1:0]  m_user,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int PAGE_BITS = ALIGN - UNIT_SIZE;
    // Wide enough for both the remaining beat count and the room left in a page.
    localparam int CW = (LEN_WIDTH + 1 > PAGE_BITS + 1) ? LEN_WIDTH + 1 : PAGE_BITS + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [CW-1:0]         rem_r;
    logic [USER_BITS-1:0]  user_r;
    logic                  last_r;

    logic                  advance;
    logic                  load_idle;
    logic                  load_split;
    logic                  fin;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CW-1:0]         src_rem;
    logic [CW-1:0]         chunk;
    logic [CW-1:0]         next_rem;

    function automatic logic [CW-1:0] min_cw(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [CW-1:0] chunk_of(input logic [CW-1:0]        rem,
                                               input logic [PAGE_BITS-1:0] page_pos);
        logic [CW-1:0] room;
        logic [CW-1:0] c;
        room = (CW'(1) << PAGE_BITS) - CW'(page_pos);
        c    = min_cw(rem, room);
        if (MAX_LEN_LOG > 0) begin
            c = min_cw(c, CW'(1) << MAX_LEN_LOG);
        end
        return c;
    endfunction

    // Chunk source: the incoming command in IDLE, the latched remainder in SPLIT.
    always_comb begin
        advance    = cke && (!m_valid || m_ready);
        src_addr   = (state == SPLIT) ? addr_r : s_addr;
        src_rem    = (state == SPLIT) ? rem_r  : CW'(s_len) + CW'(LEN_OFFSET);
        chunk      = chunk_of(src_rem, src_addr[ALIGN-1:UNIT_SIZE]);
        fin        = (chunk == src_rem);
        next_addr  = src_addr + (ADDR_WIDTH'(chunk) << UNIT_SIZE);
        next_rem   = src_rem - chunk;
        s_ready    = resetn && (state == IDLE) && advance;
        load_idle  = s_ready && s_valid;
        load_split = (state == SPLIT) && advance;

        state_next = state;
        if (load_idle && !fin) begin
            state_next = SPLIT;
        end
        if (load_split && fin) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (cke) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid    <= 1'b0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            m_cmd_last <= 1'b0;
            m_addr     <= '0;
            m_len      <= '0;
            m_user     <= '0;
            addr_r     <= '0;
            rem_r      <= '0;
            user_r     <= '0;
            last_r     <= 1'b0;
        end else if (advance) begin
            m_valid <= load_idle || load_split;
            if (load_idle || load_split) begin
                m_addr     <= src_addr;
                m_len      <= LEN_WIDTH'(chunk - CW'(LEN_OFFSET));
                m_first    <= load_idle && s_first;
                m_last     <= fin && (load_idle ? s_last : last_r);
                m_cmd_last <= fin;
                m_user     <= load_idle ? s_user : user_r;
                addr_r     <= next_addr;
                rem_r      <= next_rem;
            end
            if (load_idle) begin
                user_r <= s_user;
                last_r <= s_last;
            end
        end
    end

endmodule

// File: tb/tb_jelly_address_align_split_multi.sv
// Bench for jelly_address_align_split_multi: an uncapped and a 16-beat-capped instance,
// directed vectors plus random commands against an arithmetic chunking model.
module tb_jelly_address_align_split_multi;

    typedef struct packed {
        logic [31:0] addr;
        logic [11:0] len;
        logic        first;
        logic        last;
        logic        cmd_last;
        logic [3:0]  user;
    } chunk_t;

    typedef struct {
        int           sel;
        logic [31:0]  addr;
        logic [11:0]  len;
        logic         first;
        logic         last;
        int           n;
        chunk_t [2:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cke;
    logic [1:0]  s_first, s_last, s_valid, s_ready;
    logic [1:0]  m_first, m_last, m_cmd_last, m_valid, m_ready;
    logic [31:0] s_addr [2];
    logic [31:0] m_addr [2];
    logic [11:0] s_len  [2];
    logic [11:0] m_len  [2];
    logic [3:0]  s_user [2];
    logic [3:0]  m_user [2];

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    logic   chk_en   = 1'b0;
    int     rdy_mode [2] = '{0, 0};
    chunk_t obs_q [$];
    int     obs_cyc [$];
    chunk_t exp_q [$];
    logic   prev_hold [2] = '{1'b0, 1'b0};
    chunk_t prev_out [2];
    vec_t   tbl [7];

    jelly_address_align_split_multi #(
        .USER_WIDTH(4), .ADDR_WIDTH(32), .UNIT_SIZE(3), .LEN_WIDTH(12),
        .LEN_OFFSET(1), .ALIGN(12), .MAX_LEN_LOG(0)
    ) dut (
        .clk(clk), .resetn(resetn), .cke(cke),
        .s_first(s_first[0]), .s_last(s_last[0]), .s_addr(s_addr[0]), .s_len(s_len[0]),
        .s_user(s_user[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_first(m_first[0]), .m_last(m_last[0]), .m_cmd_last(m_cmd_last[0]),
        .m_addr(m_addr[0]), .m_len(m_len[0]), .m_user(m_user[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0])
    );

    jelly_address_align_split_multi #(
        .USER_WIDTH(4), .ADDR_WIDTH(32), .UNIT_SIZE(3), .LEN_WIDTH(12),
        .LEN_OFFSET(1), .ALIGN(12), .MAX_LEN_LOG(4)
    ) dut_cap (
        .clk(clk), .resetn(resetn), .cke(cke),
        .s_first(s_first[1]), .s_last(s_last[1]), .s_addr(s_addr[1]), .s_len(s_len[1]),
        .s_user(s_user[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_first(m_first[1]), .m_last(m_last[1]), .m_cmd_last(m_cmd_last[1]),
        .m_addr(m_addr[1]), .m_len(m_len[1]), .m_user(m_user[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic chunk_t out_of(input int k);
        return '{m_addr[k], m_len[k], m_first[k], m_last[k], m_cmd_last[k], m_user[k]};
    endfunction

    function automatic chunk_t ck(input logic [31:0] a, input logic [11:0] l,
                                  input logic f, input logic la, input logic cl);
        return '{a, l, f, la, cl, 4'h5};
    endfunction

    function automatic vec_t mkv(input int sel, input logic [31:0] a, input logic [11:0] l,
                                 input logic f, input logic la, input int n,
                                 input chunk_t c0, input chunk_t c1, input chunk_t c2);
        vec_t v;
        v.sel = sel; v.addr = a; v.len = l; v.first = f; v.last = la; v.n = n;
        v.e[0] = c0; v.e[1] = c1; v.e[2] = c2;
        return v;
    endfunction

    // Reference: walk the command page by page with plain byte arithmetic.
    task automatic model(input int sel, input logic [31:0] a0, input logic [11:0] l,
                         input logic f, input logic la, input logic [3:0] u);
        longint a;
        longint beats;
        longint cap;
        bit     head;
        chunk_t c;
        a     = longint'(a0);
        beats = longint'(l) + 1;
        cap   = (sel == 1) ? 16 : 64'h7fff_ffff;
        head  = 1'b1;
        while (beats > 0) begin
            longint room;
            longint n;
            room = ((((a >> 12) + 1) << 12) - a) / 8;
            n = beats;
            if (room < n) n = room;
            if (cap < n) n = cap;
            c.addr     = a[31:0];
            c.len      = 12'(n - 1);
            c.first    = head & f;
            c.cmd_last = (n == beats);
            c.last     = c.cmd_last & la;
            c.user     = u;
            exp_q.push_back(c);
            a     = (a + n * 8) & 64'hFFFF_FFFF;
            beats = beats - n;
            head  = 1'b0;
        end
    endtask

    // Ready generator and output monitor / property checks.
    initial begin
        m_ready = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                m_ready[k] = (rdy_mode[k] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[k] == 1);
            end
        end
    end

    always @(negedge clk) begin
        chunk_t cur;
        logic   exp_rdy;
        for (int k = 0; k < 2; k++) begin
            cur = out_of(k);
            if (chk_en) begin
                exp_rdy = resetn && (!m_valid[k] || (m_cmd_last[k] && m_ready[k]));
                if (!resetn || cke) check($sformatf("s_ready dut%0d", k), 64'(s_ready[k]), 64'(exp_rdy));
                if (prev_hold[k] && resetn)
                    check($sformatf("stall hold dut%0d", k), 64'({m_valid[k], cur}), 64'({1'b1, prev_out[k]}));
            end
            prev_hold[k] = chk_en && resetn && m_valid[k] && !m_ready[k];
            prev_out[k]  = cur;
            if (chk_en && resetn && cke && m_valid[k] && m_ready[k]) begin
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic send(input int sel, input logic [31:0] a, input logic [11:0] l,
                        input logic f, input logic la, input logic [3:0] u, output int acc);
        int  t;
        bit  got;
        @(posedge clk);
        #1;
        s_addr[sel] = a; s_len[sel] = l; s_first[sel] = f; s_last[sel] = la; s_user[sel] = u;
        s_valid[sel] = 1'b1;
        t = 0; got = 0; acc = -1;
        while (!got && t < 5000) begin
            @(negedge clk);
            if (s_ready[sel]) begin
                got = 1;
                acc = cyc;
            end
            t++;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL accept timeout dut%0d: got no s_ready expected accept", sel);
        end
        @(posedge clk);
        #1;
        s_valid[sel] = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int limit);
        int t;
        t = 0;
        while (obs_q.size() < n && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (obs_q.size() < n) begin
            n_fail++;
            $display("FAIL chunk wait timeout: got %0d chunks expected %0d", obs_q.size(), n);
        end
    endtask

    task automatic compare_all(input string tag);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++)
            check($sformatf("%s chunk%0d", tag, j), 64'(obs_q[j]), 64'(exp_q[j]));
    endtask

    task automatic clear_q();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int          acc;
        logic [31:0] ra;
        logic [11:0] rl;
        logic        rf, rla;
        logic [3:0]  ru;

        tbl[0] = mkv(0, 32'h0000_0100, 12'd7,    1'b0, 1'b1, 1,
                     ck(32'h100, 12'd7, 1'b0, 1'b1, 1'b1), '0, '0);
        tbl[1] = mkv(0, 32'h0000_0FF0, 12'd3,    1'b1, 1'b1, 2,
                     ck(32'hFF0, 12'd1, 1'b1, 1'b0, 1'b0), ck(32'h1000, 12'd1, 1'b0, 1'b1, 1'b1), '0);
        tbl[2] = mkv(0, 32'h0000_0FF8, 12'd1023, 1'b1, 1'b1, 3,
                     ck(32'hFF8, 12'd0, 1'b1, 1'b0, 1'b0), ck(32'h1000, 12'd511, 1'b0, 1'b0, 1'b0),
                     ck(32'h2000, 12'd510, 1'b0, 1'b1, 1'b1));
        tbl[3] = mkv(1, 32'h0000_0000, 12'd39,   1'b0, 1'b1, 3,
                     ck(32'h0, 12'd15, 1'b0, 1'b0, 1'b0), ck(32'h80, 12'd15, 1'b0, 1'b0, 1'b0),
                     ck(32'h100, 12'd7, 1'b0, 1'b1, 1'b1));
        tbl[4] = mkv(0, 32'h0000_0F00, 12'd31,   1'b1, 1'b1, 1,
                     ck(32'hF00, 12'd31, 1'b1, 1'b1, 1'b1), '0, '0);
        tbl[5] = mkv(0, 32'hFFFF_FFF8, 12'd1,    1'b1, 1'b0, 2,
                     ck(32'hFFFF_FFF8, 12'd0, 1'b1, 1'b0, 1'b0), ck(32'h0, 12'd0, 1'b0, 1'b0, 1'b1), '0);
        tbl[6] = mkv(1, 32'h0000_0F80, 12'd15,   1'b1, 1'b1, 1,
                     ck(32'hF80, 12'd15, 1'b1, 1'b1, 1'b1), '0, '0);

        resetn = 1'b0;
        cke    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; s_first[k] = 1'b0; s_last[k] = 1'b0;
            s_addr[k] = '0; s_len[k] = '0; s_user[k] = '0;
        end
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset m_valid dut%0d", k), 64'(m_valid[k]), 64'd0);
            check($sformatf("reset outputs dut%0d", k), 64'(out_of(k)), 64'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rdy_mode = '{1, 1};
        repeat (2) @(posedge clk);

        // Directed vectors with m_ready held high: exact chunks and back-to-back timing.
        for (int i = 0; i < 7; i++) begin
            clear_q();
            send(tbl[i].sel, tbl[i].addr, tbl[i].len, tbl[i].first, tbl[i].last, 4'h5, acc);
            wait_obs(tbl[i].n, 200);
            for (int j = 0; j < tbl[i].n && j < obs_q.size(); j++) begin
                check($sformatf("vec%0d chunk%0d", i, j), 64'(obs_q[j]), 64'(tbl[i].e[j]));
                check($sformatf("vec%0d cycle%0d", i, j), 64'(obs_cyc[j]), 64'(acc + 1 + j));
            end
            repeat (4) @(negedge clk);
            check($sformatf("vec%0d chunk count", i), 64'(obs_q.size()), 64'(tbl[i].n));
        end

        // Long split under random back-pressure.
        clear_q();
        rdy_mode[0] = 2;
        model(0, 32'h0FF8, 12'd1023, 1'b1, 1'b1, 4'h5);
        send(0, 32'h0FF8, 12'd1023, 1'b1, 1'b1, 4'h5, acc);
        wait_obs(3, 200);
        repeat (4) @(negedge clk);
        compare_all("random ready split");

        // Clock enable low freezes a stalled chunk even with m_ready asserted.
        rdy_mode[0] = 0;
        repeat (3) @(posedge clk);
        clear_q();
        model(0, 32'h0FF8, 12'd1023, 1'b0, 1'b1, 4'h9);
        send(0, 32'h0FF8, 12'd1023, 1'b0, 1'b1, 4'h9, acc);
        @(posedge clk);
        #1;
        cke = 1'b0;
        rdy_mode[0] = 1;
        repeat (6) @(negedge clk);
        check("cke hold valid", 64'(m_valid[0]), 64'd1);
        check("cke hold addr", 64'(m_addr[0]), 64'h0FF8);
        check("cke hold no handshake", 64'(obs_q.size()), 64'd0);
        @(posedge clk);
        #1;
        cke = 1'b1;
        wait_obs(3, 200);
        repeat (4) @(negedge clk);
        compare_all("cke resume");

        // Reset while the second chunk is on the output.
        clear_q();
        send(0, 32'h0FF8, 12'd1023, 1'b1, 1'b1, 4'h5, acc);
        wait_obs(1, 200);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid-split reset m_valid", 64'(m_valid[0]), 64'd0);
        check("mid-split reset outputs", 64'(out_of(0)), 64'd0);
        check("mid-split reset chunks seen", 64'(obs_q.size()), 64'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_q();
        send(0, 32'h0000_0000, 12'd0, 1'b1, 1'b1, 4'h5, acc);
        wait_obs(1, 50);
        repeat (6) @(negedge clk);
        check("post-reset single chunk count", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() > 0)
            check("post-reset single chunk", 64'(obs_q[0]), 64'(ck(32'h0, 12'd0, 1'b1, 1'b1, 1'b1)));

        // Random commands with random back-pressure on each instance.
        for (int sel = 0; sel < 2; sel++) begin
            clear_q();
            rdy_mode[sel] = 2;
            for (int i = 0; i < 40; i++) begin
                ra = $urandom & 32'hFFFF_FFF8;
                if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFF8 - 12'($urandom_range(0, 31) << 3);
                rl  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 40));
                rf  = 1'($urandom_range(0, 1));
                rla = 1'($urandom_range(0, 1));
                ru  = 4'($urandom_range(0, 15));
                model(sel, ra, rl, rf, rla, ru);
                send(sel, ra, rl, rf, rla, ru, acc);
            end
            wait_obs(exp_q.size(), 20000);
            repeat (4) @(negedge clk);
            compare_all($sformatf("random dut%0d", sel));
            rdy_mode[sel] = 1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
